// File: rtl/lab2q_sysid_pkg.sv
// lab2q_sysid_checker shared types and constants.
// States, sysid word addresses, default expected values.
package lab2q_sysid_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_LAT_ID,
    S_RD_TS,
    S_LAT_TS,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] DEF_EXPECTED_ID = 32'd1;
  localparam logic [31:0] DEF_EXPECTED_TS = 32'd1432487389;

endpackage

// File: rtl/lab2q_sysid_if.sv
// Avalon-MM read bus between the checker and the sysid slave.
// Master drives address/read, slave returns data and stall.
interface lab2q_sysid_if;

  logic        address;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address,
    output read,
    input  readdata,
    input  waitrequest
  );

  modport slave (
    input  address,
    input  read,
    output readdata,
    output waitrequest
  );

endinterface

// File: rtl/lab2q_sysid_rd_ctr.sv
// Read counters: latency down-counter and stall up-counter.
// Terminal counts tell the FSM when to capture or abort.
module lab2q_sysid_rd_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       lat_load,
  input  logic [1:0] lat_val,
  input  logic       lat_en,
  input  logic       wait_en,
  input  logic       wait_clr,
  output logic       lat_tc,
  output logic       wait_tc
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  lat_cnt;
  logic [15:0] wait_cnt;

  // latency countdown, loaded on read accept
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lat_cnt <= '0;
    end else if (lat_load) begin
      lat_cnt <= lat_val;
    end else if (lat_en && lat_cnt != 2'd0) begin
      lat_cnt <= lat_cnt - 2'd1;
    end
  end

  // consecutive stall cycles of the current read
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (wait_clr) begin
      wait_cnt <= '0;
    end else if (wait_en) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  assign lat_tc  = (lat_cnt == 2'd0);
  assign wait_tc = (wait_cnt == WAIT_LAST);

endmodule

// File: rtl/lab2q_sysid_checker.sv
// Reads sysid ID and timestamp words and checks them.
// Reports pass/fail/timeout so mismatched images are refused.
module lab2q_sysid_checker
  import lab2q_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID  = DEF_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS  = DEF_EXPECTED_TS,
  parameter int          READ_LATENCY = 0,
  parameter int          TIMEOUT      = 255,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  lab2q_sysid_if.master        bus,
  output logic                 busy,
  output logic                 done,
  output logic                 id_ok,
  output logic                 ts_ok,
  output logic                 timeout,
  output logic [31:0]          id_value,
  output logic [31:0]          ts_value
);

  localparam bit NO_LAT = (READ_LATENCY == 0);
  localparam logic [1:0] LAT_V =
    (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

  state_t      state, state_nx;
  logic        auto_q;
  logic        rd_st, acc, stall;
  logic        lat_tc, wait_tc;
  logic        cap_id, cap_ts, fresh;
  logic [31:0] id_nx, ts_nx;

  assign rd_st = (state == S_RD_ID) || (state == S_RD_TS);
  assign stall = rd_st && bus.waitrequest;
  assign acc   = rd_st && !bus.waitrequest;

  lab2q_sysid_rd_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_ctr (
    .clock    (clock),
    .reset_n  (reset_n),
    .lat_load (acc),
    .lat_val  (LAT_V),
    .lat_en   ((state == S_LAT_ID) || (state == S_LAT_TS)),
    .wait_en  (stall),
    .wait_clr (!stall),
    .lat_tc   (lat_tc),
    .wait_tc  (wait_tc)
  );

  // next state and capture values
  always_comb begin
    state_nx = state;
    cap_id   = 1'b0;
    cap_ts   = 1'b0;
    unique case (state)
      S_IDLE:
        if (start || auto_q) state_nx = S_RD_ID;
      S_RD_ID:
        if (acc) begin
          cap_id   = NO_LAT;
          state_nx = NO_LAT ? S_RD_TS : S_LAT_ID;
        end else if (wait_tc) begin
          state_nx = S_FAIL;
        end
      S_LAT_ID:
        if (lat_tc) begin
          cap_id   = 1'b1;
          state_nx = S_RD_TS;
        end
      S_RD_TS:
        if (acc) begin
          cap_ts   = NO_LAT;
          state_nx = NO_LAT ? S_DONE : S_LAT_TS;
        end else if (wait_tc) begin
          state_nx = S_FAIL;
        end
      S_LAT_TS:
        if (lat_tc) begin
          cap_ts   = 1'b1;
          state_nx = S_DONE;
        end
      S_DONE, S_FAIL:
        if (start) state_nx = S_RD_ID;
      default:
        state_nx = S_IDLE;
    endcase
    fresh = (state_nx == S_RD_ID) && (state != S_RD_ID);
    id_nx = id_value;
    ts_nx = ts_value;
    if (fresh) begin
      id_nx = '0;
      ts_nx = '0;
    end
    if (cap_id) id_nx = bus.readdata;
    if (cap_ts) ts_nx = bus.readdata;
  end

  // state, bus strobes and registered status
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      auto_q      <= AUTO_START;
      bus.read    <= 1'b0;
      bus.address <= SYSID_ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      state       <= state_nx;
      auto_q      <= 1'b0;
      bus.read    <= (state_nx == S_RD_ID) ||
                     (state_nx == S_RD_TS);
      bus.address <= (state_nx == S_RD_TS) ?
                     SYSID_ADDR_TS : SYSID_ADDR_ID;
      busy        <= (state_nx == S_RD_ID)  ||
                     (state_nx == S_LAT_ID) ||
                     (state_nx == S_RD_TS)  ||
                     (state_nx == S_LAT_TS);
      done        <= (state_nx == S_DONE) ||
                     (state_nx == S_FAIL);
      timeout     <= (state_nx == S_FAIL);
      id_ok       <= (state_nx == S_DONE) &&
                     (id_nx == EXPECTED_ID);
      ts_ok       <= (state_nx == S_DONE) &&
                     (ts_nx == EXPECTED_TS);
      id_value    <= id_nx;
      ts_value    <= ts_nx;
    end
  end

endmodule

// File: tb/tb_lab2q_sysid_checker.sv
// Directed bench for lab2q_sysid_checker.
// Three instances: L=0 auto, L=2 auto, L=0 manual start.
module tb_lab2q_sysid_checker;

  localparam logic [31:0] TS = 32'h556205DD;

  typedef struct {
    logic [31:0] id_w;
    logic [31:0] ts_w;
    logic        e_id_ok;
    logic        e_ts_ok;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic rst_a, rst_b, rst_c;
  logic st_a, st_b, st_c;
  logic wr_a;
  logic [31:0] id_a, ts_a;

  logic busy_a, done_a, idok_a, tsok_a, tmo_a;
  logic busy_b, done_b, idok_b, tsok_b, tmo_b;
  logic busy_c, done_c, idok_c, tsok_c, tmo_c;
  logic [31:0] idv_a, tsv_a, idv_b, tsv_b, idv_c, tsv_c;

  lab2q_sysid_if bus_a ();
  lab2q_sysid_if bus_b ();
  lab2q_sysid_if bus_c ();

  assign bus_a.readdata    = bus_a.address ? ts_a : id_a;
  assign bus_a.waitrequest = wr_a;

  logic [1:0] pv = '0;
  logic [1:0] pa = '0;
  always @(posedge clk) begin
    pv <= {pv[0], bus_b.read & ~bus_b.waitrequest};
    pa <= {pa[0], bus_b.address};
  end
  assign bus_b.readdata = !pv[1] ? 32'hDEADBEEF :
                          (pa[1] ? TS : 32'd1);
  assign bus_b.waitrequest = 1'b0;

  assign bus_c.readdata    = bus_c.address ? TS : 32'd1;
  assign bus_c.waitrequest = 1'b0;

  lab2q_sysid_checker #(
    .READ_LATENCY (0),
    .TIMEOUT      (4),
    .AUTO_START   (1'b1)
  ) dut_a (
    .clock    (clk),
    .reset_n  (rst_a),
    .start    (st_a),
    .bus      (bus_a),
    .busy     (busy_a),
    .done     (done_a),
    .id_ok    (idok_a),
    .ts_ok    (tsok_a),
    .timeout  (tmo_a),
    .id_value (idv_a),
    .ts_value (tsv_a)
  );

  lab2q_sysid_checker #(
    .READ_LATENCY (2),
    .AUTO_START   (1'b1)
  ) dut_b (
    .clock    (clk),
    .reset_n  (rst_b),
    .start    (st_b),
    .bus      (bus_b),
    .busy     (busy_b),
    .done     (done_b),
    .id_ok    (idok_b),
    .ts_ok    (tsok_b),
    .timeout  (tmo_b),
    .id_value (idv_b),
    .ts_value (tsv_b)
  );

  lab2q_sysid_checker #(
    .READ_LATENCY (0),
    .AUTO_START   (1'b0)
  ) dut_c (
    .clock    (clk),
    .reset_n  (rst_c),
    .start    (st_c),
    .bus      (bus_c),
    .busy     (busy_c),
    .done     (done_c),
    .id_ok    (idok_c),
    .ts_ok    (tsok_c),
    .timeout  (tmo_c),
    .id_value (idv_c),
    .ts_value (tsv_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, got, exp);
    end
  endtask

  vec_t vec [5];
  logic exp_rd [1:6];
  int   cyc;
  int   nrd;
  int   nrise;
  logic seen;
  logic pdone;

  initial begin
    vec[0] = '{32'd1,        TS,           1'b1, 1'b1};
    vec[1] = '{32'd2,        TS,           1'b0, 1'b1};
    vec[2] = '{32'd1,        32'h556205DC, 1'b1, 1'b0};
    vec[3] = '{32'h80000001, TS,           1'b0, 1'b1};
    vec[4] = '{32'd0,        32'hD56205DD, 1'b0, 1'b0};
    exp_rd = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    rst_a = 0; rst_b = 0; rst_c = 0;
    st_a = 0;  st_b = 0;  st_c = 0;
    wr_a = 0;  id_a = 32'd1; ts_a = TS;
    tick();
    tick();

    chk("rst_read",    {31'd0, bus_a.read},    0);
    chk("rst_addr",    {31'd0, bus_a.address}, 0);
    chk("rst_busy",    {31'd0, busy_a},  0);
    chk("rst_done",    {31'd0, done_a},  0);
    chk("rst_ok",      {30'd0, idok_a, tsok_a}, 0);
    chk("rst_tmo",     {31'd0, tmo_a},   0);
    chk("rst_idv",     idv_a, 0);
    chk("rst_tsv",     tsv_a, 0);

    // instance A: auto start, back-to-back reads
    rst_a = 1;
    tick();
    chk("a_c1_rd",   {31'd0, bus_a.read},    1);
    chk("a_c1_addr", {31'd0, bus_a.address}, 0);
    chk("a_c1_busy", {31'd0, busy_a},        1);
    tick();
    chk("a_c2_rd",   {31'd0, bus_a.read},    1);
    chk("a_c2_addr", {31'd0, bus_a.address}, 1);
    chk("a_c2_done", {31'd0, done_a},        0);
    tick();
    chk("a_c3_done", {31'd0, done_a},        1);
    chk("a_c3_rd",   {31'd0, bus_a.read},    0);
    chk("a_c3_ok",   {30'd0, idok_a, tsok_a}, 3);
    chk("a_c3_tmo",  {31'd0, tmo_a},         0);
    chk("a_c3_idv",  idv_a, 32'd1);
    chk("a_c3_tsv",  tsv_a, TS);

    for (int i = 0; i < 5; i++) begin
      id_a = vec[i].id_w;
      ts_a = vec[i].ts_w;
      st_a = 1;
      tick();
      st_a = 0;
      chk("v_busy", {31'd0, busy_a}, 1);
      chk("v_done_clr", {31'd0, done_a}, 0);
      cyc = 1;
      while (!done_a && cyc < 12) begin
        tick();
        cyc++;
      end
      chk("v_cycles", cyc, 3);
      chk("v_id_ok", {31'd0, idok_a}, {31'd0, vec[i].e_id_ok});
      chk("v_ts_ok", {31'd0, tsok_a}, {31'd0, vec[i].e_ts_ok});
      chk("v_idv",   idv_a, vec[i].id_w);
      chk("v_tsv",   tsv_a, vec[i].ts_w);
    end

    // instance A: timeout after 4 stalled cycles
    id_a = 32'd1;
    ts_a = TS;
    wr_a = 1;
    st_a = 1;
    tick();
    st_a = 0;
    tick();
    tick();
    chk("to_c3_rd",   {31'd0, bus_a.read},    1);
    chk("to_c3_addr", {31'd0, bus_a.address}, 0);
    tick();
    chk("to_c4_rd",  {31'd0, bus_a.read}, 1);
    chk("to_c4_tmo", {31'd0, tmo_a},      0);
    tick();
    chk("to_c5_rd",   {31'd0, bus_a.read}, 0);
    chk("to_c5_tmo",  {31'd0, tmo_a},      1);
    chk("to_c5_done", {31'd0, done_a},     1);
    chk("to_c5_busy", {31'd0, busy_a},     0);
    chk("to_c5_ok",   {30'd0, idok_a, tsok_a}, 0);
    tick();
    chk("to_hold", {31'd0, tmo_a}, 1);

    wr_a = 0;
    st_a = 1;
    tick();
    st_a = 0;
    chk("to_rs_tmo", {31'd0, tmo_a}, 0);
    cyc = 1;
    while (!done_a && cyc < 12) begin
      tick();
      cyc++;
    end
    chk("to_rs_cyc", cyc, 3);
    chk("to_rs_ok",  {30'd0, idok_a, tsok_a}, 3);
    chk("to_rs_tmo2", {31'd0, tmo_a}, 0);

    // instance B: read latency 2
    rst_b = 1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("b_rd",   {31'd0, bus_b.read}, {31'd0, exp_rd[c]});
      chk("b_done", {31'd0, done_b},     0);
    end
    tick();
    chk("b_c7_done", {31'd0, done_b}, 1);
    chk("b_c7_idv",  idv_b, 32'd1);
    chk("b_c7_tsv",  tsv_b, TS);
    chk("b_c7_ok",   {30'd0, idok_b, tsok_b}, 3);

    // instance B: reset during LAT_TS
    st_b = 1;
    tick();
    st_b = 0;
    tick();
    tick();
    tick();
    tick();
    chk("b_lat_busy", {31'd0, busy_b}, 1);
    chk("b_lat_idv",  idv_b, 32'd1);
    #1;
    rst_b = 0;
    #1;
    chk("b_ar_rd",   {31'd0, bus_b.read}, 0);
    chk("b_ar_busy", {31'd0, busy_b},     0);
    chk("b_ar_done", {31'd0, done_b},     0);
    chk("b_ar_idv",  idv_b, 0);
    chk("b_ar_tsv",  tsv_b, 0);
    tick();
    tick();
    chk("b_ar_hold", {31'd0, busy_b | done_b}, 0);
    rst_b = 1;
    cyc = 0;
    while (!done_b && cyc < 15) begin
      tick();
      cyc++;
    end
    chk("b_re_cyc", cyc, 7);
    chk("b_re_tsv", tsv_b, TS);
    chk("b_re_ok",  {30'd0, idok_b, tsok_b}, 3);

    // instance C: manual start, start while busy ignored
    rst_c = 1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      seen = seen | bus_c.read | busy_c;
    end
    chk("c_no_auto", {31'd0, seen}, 0);
    st_c = 1;
    tick();
    nrd = 0;
    nrise = 0;
    pdone = 0;
    for (int c = 1; c <= 10; c++) begin
      if (bus_c.read) nrd++;
      if (done_c && !pdone) nrise++;
      pdone = done_c;
      if (c == 2) st_c = 0;
      tick();
    end
    chk("c_nreads", nrd, 2);
    chk("c_ndone",  nrise, 1);
    chk("c_done",   {31'd0, done_c}, 1);
    chk("c_ok",     {30'd0, idok_c, tsok_c}, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lab2q_sysid_checker.md
# lab2q_sysid_checker

Avalon-MM read master that sits directly upstream of the system-ID slave and consumes its two read-only words. After reset, or on request, it reads address 0 (system ID) then address 1 (build timestamp), captures both, compares them against expected values and reports pass, fail or timeout. Software or board-level logic uses the status to refuse to run against a mismatched FPGA image.

## Interface
- `EXPECTED_ID`, default 32'd1: required value at address 0.
- `EXPECTED_TS`, default 32'd1432487389 (0x556205DD): required value at address 1.
- `READ_LATENCY`, default 0: fixed slave read latency in cycles, range 0..3.
- `TIMEOUT`, default 255: maximum consecutive `waitrequest` cycles before abort, range 1..65535.
- `AUTO_START`, default 1: when 1, a check starts automatically after reset.

- `clock`  in  1  single clock; all logic rising-edge.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  one-cycle pulse that requests a (re)check.
- `address`  out  1  Avalon address to the sysid slave.
- `read`  out  1  Avalon read strobe.
- `readdata`  in  32  Avalon read data.
- `waitrequest`  in  1  Avalon stall; tie 0 for the zero-wait sysid slave.
- `busy`  out  1  check in progress.
- `done`  out  1  last check completed; sticky until next start.
- `id_ok`  out  1  captured ID == `EXPECTED_ID`.
- `ts_ok`  out  1  captured timestamp == `EXPECTED_TS`.
- `timeout`  out  1  last check aborted on `waitrequest`.
- `id_value`  out  32  captured ID word.
- `ts_value`  out  32  captured timestamp word.

## Operation
- States: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, DONE, FAIL.
- IDLE -> RD_ID when `start`=1, or on the first post-reset cycle if `AUTO_START`=1. Entering RD_ID clears `done`, `id_ok`, `ts_ok`, `timeout`, `id_value` and `ts_value`.
- RD_ID: `read`=1, `address`=0. The read is accepted when `waitrequest`=0.
  - On accept with `READ_LATENCY`=0: capture `readdata` into `id_value` the same cycle, then go to RD_TS.
  - On accept with `READ_LATENCY`>0: go to LAT_ID with the latency counter loaded to `READ_LATENCY`-1.
- LAT_ID: `read`=0. Count down; when the count is 0, capture `readdata` and go to RD_TS.
- RD_TS and LAT_TS: identical to RD_ID and LAT_ID, with `address`=1 and capture into `ts_value`. They exit to DONE.
- DONE: `done`=1. `id_ok` = (`id_value`==`EXPECTED_ID`) and `ts_ok` = (`ts_value`==`EXPECTED_TS`), registered on entry.
- Timeout: the wait counter increments each RD_* cycle with `waitrequest`=1 and resets to 0 on accept.
  - On reaching `TIMEOUT`, go to FAIL: `read`=0, `timeout`=1, `done`=1, `id_ok`=`ts_ok`=0.
- `start` in DONE or FAIL restarts at RD_ID. `start` while `busy` is ignored.
- `busy`=1 exactly in RD_ID, LAT_ID, RD_TS and LAT_TS.
- Comparisons are full 32-bit equality; no masking.

## Timing
- Reset values: `read`=0, `address`=0, `busy`=0, `done`=0, `id_ok`=0, `ts_ok`=0, `timeout`=0, `id_value`=0, `ts_value`=0, state IDLE, counters 0.
- Reset asserted mid-check: `read` drops asynchronously and no capture occurs.
- Outputs are registered. `read` and `address` change only on clock edges.
- `read` and `address` are held stable while `waitrequest`=1.
- Latency with `READ_LATENCY`=L, zero wait states, `AUTO_START`=1:
  - Cycle 0 after reset release: IDLE.
  - Cycle 1: RD_ID.
  - Each word takes 1+L cycles.
  - `done` rises at cycle 3+2L.
- With L=0 there is a back-to-back read: `address` goes 0 then 1 on consecutive cycles with `read` held high.

## Structure
- Package `lab2q_sysid_pkg`:
  - state enum;
  - address constants `SYSID_ADDR_ID`=0 and `SYSID_ADDR_TS`=1;
  - default expected-value constants.
- One sub-module, `lab2q_sysid_rd_ctr`: a shared down-counter for latency plus an up-counter for timeout, with load, enable and terminal-count outputs.
- The FSM and capture registers stay in the top module.

## Test plan
- L=0, zero-wait sysid model returning 1 and 1432487389 -> `done` at cycle 3, `id_ok`=`ts_ok`=1, `timeout`=0, `id_value`=1, `ts_value`=0x556205DD.
- Model returns 2 at address 0 -> `done`=1, `id_ok`=0, `ts_ok`=1, `id_value`=2.
- L=2, model delays data by 2 cycles -> correct capture, `done` at cycle 7, `read` low during the latency cycles.
- `waitrequest` held high, `TIMEOUT`=4 -> FAIL after 4 stalled cycles, `read`=0, `timeout`=1, `done`=1.
  - Then release `waitrequest` and pulse `start` -> passing check, with `timeout` cleared.
- `AUTO_START`=0 -> no `read` until `start`.
  - `start` pulsed again while `busy` -> ignored, single sequence only.
- Assert `reset_n` during LAT_TS -> all outputs return to their reset values immediately; with `AUTO_START`=1, a fresh check completes after release.
